// File: rtl/tile_game_pkg.sv
// ============================================================================
// Module      : tile_game_pkg
// Description : Shared types and constants for the 4x4 tile-matching game.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tile_game_pkg;

    localparam int NUM_TILES = 16;
    localparam int NUM_PAIRS = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FIRST   = 3'd1,
        ST_SECOND  = 3'd2,
        ST_COMPARE = 3'd3,
        ST_HOLD    = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // Tile i sits at bits [3i+2:3i]; tiles i and i+8 carry the same value.
    localparam logic [NUM_TILES*3-1:0] TILE_LAYOUT = {
        3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0,
        3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0
    };

    function automatic logic [2:0] tile_value(input logic [3:0] idx);
        return TILE_LAYOUT[int'(idx)*3 +: 3];
    endfunction

endpackage

`default_nettype wire

// File: rtl/game_timer.sv
// ============================================================================
// Module      : game_timer
// Description : Per-second tick prescaler driving a seconds-remaining counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_timer #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int TIME_LIMIT    = 99
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       load_i,
    output logic [6:0] time_left_o
);

    localparam int TICK_W = $clog2(TICKS_PER_SEC + 1);

    logic [TICK_W-1:0] tick_q;
    logic [6:0]        time_left_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || load_i) begin
            tick_q      <= '0;
            time_left_q <= 7'(TIME_LIMIT);
        end else if (en_i) begin
            if (tick_q == TICK_W'(TICKS_PER_SEC - 1)) begin
                tick_q <= '0;
                // Stop at zero; the FSM leaves the active states one cycle later.
                if (time_left_q != 7'd0) begin
                    time_left_q <= time_left_q - 7'd1;
                end
            end else begin
                tick_q <= tick_q + 1'b1;
            end
        end
    end

    assign time_left_o = time_left_q;

endmodule

`default_nettype wire

// File: rtl/match_engine.sv
// ============================================================================
// Module      : match_engine
// Description : Memory-match game core: pick two tiles, compare, score, time out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module match_engine
    import tile_game_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int TIME_LIMIT    = 99,
    parameter int MISMATCH_HOLD = 25000000
) (
    input  logic                 CLOCK_50,
    input  logic                 userquit,
    input  logic                 ingameOn,
    input  logic                 select,
    input  logic [3:0]           cursor,
    output logic                 gameOver,
    output logic                 win,
    output logic [NUM_TILES-1:0] revealed,
    output logic [NUM_TILES-1:0] matched,
    output logic [3:0]           score,
    output logic [7:0]           attempts,
    output logic [6:0]           time_left
);

    localparam int HOLD_W = $clog2(MISMATCH_HOLD + 1);

    state_e                state_q;
    logic [3:0]            idx1_q;
    logic [3:0]            idx2_q;
    logic [HOLD_W-1:0]     hold_q;
    logic                  game_over_q;
    logic                  win_q;
    logic [NUM_TILES-1:0]  revealed_q;
    logic [NUM_TILES-1:0]  matched_q;
    logic [3:0]            score_q;
    logic [7:0]            attempts_q;

    logic w_active;
    logic w_timeout;
    logic w_sel;
    logic w_pair_eq;
    logic w_final_pair;

    assign w_active     = (state_q == ST_FIRST) || (state_q == ST_SECOND) ||
                          (state_q == ST_COMPARE) || (state_q == ST_HOLD);
    assign w_timeout    = (time_left == 7'd0);
    assign w_sel        = select && ingameOn && !w_timeout;
    assign w_pair_eq    = (tile_value(idx1_q) == tile_value(idx2_q));
    assign w_final_pair = (state_q == ST_COMPARE) && w_pair_eq &&
                          (score_q == 4'(NUM_PAIRS - 1));

    game_timer #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .TIME_LIMIT    (TIME_LIMIT)
    ) u_game_timer (
        .clk_i       (CLOCK_50),
        .rst_i       (userquit),
        .en_i        (w_active),
        .load_i      ((state_q == ST_IDLE) && ingameOn),
        .time_left_o (time_left)
    );

    always_ff @(posedge CLOCK_50) begin
        if (userquit) begin
            state_q     <= ST_IDLE;
            idx1_q      <= '0;
            idx2_q      <= '0;
            hold_q      <= '0;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
            revealed_q  <= '0;
            matched_q   <= '0;
            score_q     <= '0;
            attempts_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ingameOn) begin
                        revealed_q <= '0;
                        matched_q  <= '0;
                        score_q    <= '0;
                        attempts_q <= '0;
                        hold_q     <= '0;
                        state_q    <= ST_FIRST;
                    end
                end
                ST_FIRST: begin
                    if (w_sel && !matched_q[cursor]) begin
                        revealed_q[cursor] <= 1'b1;
                        idx1_q             <= cursor;
                        state_q            <= ST_SECOND;
                    end
                end
                ST_SECOND: begin
                    if (w_sel && !matched_q[cursor] && (cursor != idx1_q)) begin
                        revealed_q[cursor] <= 1'b1;
                        idx2_q             <= cursor;
                        state_q            <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (attempts_q != 8'hFF) begin
                        attempts_q <= attempts_q + 8'd1;
                    end
                    if (w_pair_eq) begin
                        matched_q[idx1_q] <= 1'b1;
                        matched_q[idx2_q] <= 1'b1;
                        score_q           <= score_q + 4'd1;
                        state_q           <= ST_FIRST;
                    end else begin
                        hold_q  <= '0;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_q == HOLD_W'(MISMATCH_HOLD - 1)) begin
                        revealed_q[idx1_q] <= 1'b0;
                        revealed_q[idx2_q] <= 1'b0;
                        hold_q             <= '0;
                        state_q            <= ST_FIRST;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase

            // Completing the last pair beats both a quit request and a timeout.
            if (w_final_pair) begin
                state_q     <= ST_DONE;
                game_over_q <= 1'b1;
                win_q       <= 1'b1;
            end else if (w_active && !ingameOn) begin
                state_q <= ST_IDLE;
            end else if (w_active && w_timeout) begin
                state_q     <= ST_DONE;
                game_over_q <= 1'b1;
                win_q       <= 1'b0;
            end
        end
    end

    assign gameOver = game_over_q;
    assign win      = win_q;
    assign revealed = revealed_q;
    assign matched  = matched_q;
    assign score    = score_q;
    assign attempts = attempts_q;

endmodule

`default_nettype wire

// File: tb/tb_match_engine.sv
// ============================================================================
// Module      : tb_match_engine
// Description : Directed self-checking bench for match_engine (small timing params).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_match_engine;

    logic        clk = 1'b0;
    logic        userquit = 1'b0;
    logic        ingameOn = 1'b0;
    logic        select = 1'b0;
    logic [3:0]  cursor = 4'd0;
    logic        gameOver;
    logic        win;
    logic [15:0] revealed;
    logic [15:0] matched;
    logic [3:0]  score;
    logic [7:0]  attempts;
    logic [6:0]  time_left;

    int n_cmp  = 0;
    int n_fail = 0;

    match_engine #(
        .TICKS_PER_SEC (10),
        .TIME_LIMIT    (5),
        .MISMATCH_HOLD (4)
    ) dut (
        .CLOCK_50  (clk),
        .userquit  (userquit),
        .ingameOn  (ingameOn),
        .select    (select),
        .cursor    (cursor),
        .gameOver  (gameOver),
        .win       (win),
        .revealed  (revealed),
        .matched   (matched),
        .score     (score),
        .attempts  (attempts),
        .time_left (time_left)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pick(input logic [3:0] c);
        cursor = c;
        select = 1'b1;
        tick();
        select = 1'b0;
    endtask

    // Reset, then raise ingameOn: after this the game is in FIRST with time_left=5.
    task automatic start_game();
        userquit = 1'b1;
        ingameOn = 1'b0;
        select   = 1'b0;
        tick();
        userquit = 1'b0;
        ingameOn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        userquit = 1'b1;
        tick();
        tick();
        userquit = 1'b0;
        n_cmp++; if (gameOver !== 1'b0) begin n_fail++; $display("FAIL reset_gameOver: got %b want 0", gameOver); end
        n_cmp++; if (win !== 1'b0) begin n_fail++; $display("FAIL reset_win: got %b want 0", win); end
        n_cmp++; if (revealed !== 16'h0000) begin n_fail++; $display("FAIL reset_revealed: got %h want 0000", revealed); end
        n_cmp++; if (matched !== 16'h0000) begin n_fail++; $display("FAIL reset_matched: got %h want 0000", matched); end
        n_cmp++; if (score !== 4'd0) begin n_fail++; $display("FAIL reset_score: got %0d want 0", score); end
        n_cmp++; if (attempts !== 8'd0) begin n_fail++; $display("FAIL reset_attempts: got %0d want 0", attempts); end
        n_cmp++; if (time_left !== 7'd5) begin n_fail++; $display("FAIL reset_time_left: got %0d want 5", time_left); end
    endtask

    task automatic test_match();
        start_game();
        n_cmp++; if (time_left !== 7'd5) begin n_fail++; $display("FAIL match_time_load: got %0d want 5", time_left); end
        pick(4'd0);
        n_cmp++; if (revealed !== 16'h0001) begin n_fail++; $display("FAIL match_reveal1: got %h want 0001", revealed); end
        pick(4'd8);
        n_cmp++; if (revealed !== 16'h0101) begin n_fail++; $display("FAIL match_reveal2: got %h want 0101", revealed); end
        tick();
        n_cmp++; if (matched !== 16'h0101) begin n_fail++; $display("FAIL match_mask: got %h want 0101", matched); end
        n_cmp++; if (score !== 4'd1) begin n_fail++; $display("FAIL match_score: got %0d want 1", score); end
        n_cmp++; if (attempts !== 8'd1) begin n_fail++; $display("FAIL match_attempts: got %0d want 1", attempts); end
        // Back in FIRST: a fresh pick is accepted.
        pick(4'd1);
        n_cmp++; if (revealed !== 16'h0103) begin n_fail++; $display("FAIL match_back_in_first: got %h want 0103", revealed); end
        ingameOn = 1'b0;
        tick();
        tick();
        n_cmp++; if (matched !== 16'h0101) begin n_fail++; $display("FAIL quit_keeps_matched: got %h want 0101", matched); end
        n_cmp++; if (gameOver !== 1'b0) begin n_fail++; $display("FAIL quit_gameOver: got %b want 0", gameOver); end
    endtask

    task automatic test_mismatch();
        start_game();
        pick(4'd1);
        pick(4'd2);
        n_cmp++; if (revealed !== 16'h0006) begin n_fail++; $display("FAIL mis_reveal: got %h want 0006", revealed); end
        tick();
        n_cmp++; if (attempts !== 8'd1) begin n_fail++; $display("FAIL mis_attempts: got %0d want 1", attempts); end
        n_cmp++; if (revealed !== 16'h0006) begin n_fail++; $display("FAIL mis_hold_start: got %h want 0006", revealed); end
        pick(4'd5);
        tick();
        tick();
        n_cmp++; if (revealed !== 16'h0006) begin n_fail++; $display("FAIL mis_hold_end: got %h want 0006", revealed); end
        tick();
        n_cmp++; if (revealed !== 16'h0000) begin n_fail++; $display("FAIL mis_hidden: got %h want 0000", revealed); end
        n_cmp++; if (matched !== 16'h0000) begin n_fail++; $display("FAIL mis_matched: got %h want 0000", matched); end
        n_cmp++; if (score !== 4'd0) begin n_fail++; $display("FAIL mis_score: got %0d want 0", score); end
    endtask

    task automatic test_ignored();
        start_game();
        pick(4'd3);
        pick(4'd3);
        n_cmp++; if (revealed !== 16'h0008) begin n_fail++; $display("FAIL ign_same_tile: got %h want 0008", revealed); end
        pick(4'd11);
        tick();
        n_cmp++; if (matched !== 16'h0808) begin n_fail++; $display("FAIL ign_pair_3_11: got %h want 0808", matched); end
        n_cmp++; if (attempts !== 8'd1) begin n_fail++; $display("FAIL ign_attempts: got %0d want 1", attempts); end
        pick(4'd3);
        n_cmp++; if (revealed !== 16'h0808) begin n_fail++; $display("FAIL ign_matched_pick: got %h want 0808", revealed); end
        pick(4'd4);
        pick(4'd12);
        tick();
        n_cmp++; if (matched !== 16'h1818) begin n_fail++; $display("FAIL ign_pair_4_12: got %h want 1818", matched); end
        n_cmp++; if (score !== 4'd2) begin n_fail++; $display("FAIL ign_score: got %0d want 2", score); end
    endtask

    task automatic test_win();
        start_game();
        for (int i = 0; i < 8; i++) begin
            pick(4'(i));
            pick(4'(i + 8));
            tick();
        end
        n_cmp++; if (gameOver !== 1'b1) begin n_fail++; $display("FAIL win_gameOver: got %b want 1", gameOver); end
        n_cmp++; if (win !== 1'b1) begin n_fail++; $display("FAIL win_flag: got %b want 1", win); end
        n_cmp++; if (score !== 4'd8) begin n_fail++; $display("FAIL win_score: got %0d want 8", score); end
        n_cmp++; if (matched !== 16'hFFFF) begin n_fail++; $display("FAIL win_matched: got %h want ffff", matched); end
        n_cmp++; if (attempts !== 8'd8) begin n_fail++; $display("FAIL win_attempts: got %0d want 8", attempts); end
        n_cmp++; if (time_left !== 7'd3) begin n_fail++; $display("FAIL win_time_left: got %0d want 3", time_left); end
        ingameOn = 1'b0;
        tick();
        tick();
        ingameOn = 1'b1;
        tick();
        pick(4'd0);
        for (int i = 0; i < 12; i++) tick();
        n_cmp++; if (gameOver !== 1'b1 || win !== 1'b1) begin n_fail++; $display("FAIL done_hold_flags: got %b%b want 11", gameOver, win); end
        n_cmp++; if (time_left !== 7'd3) begin n_fail++; $display("FAIL done_hold_time: got %0d want 3", time_left); end
        n_cmp++; if (score !== 4'd8) begin n_fail++; $display("FAIL done_hold_score: got %0d want 8", score); end
    endtask

    task automatic test_reset_in_done();
        userquit = 1'b1;
        tick();
        userquit = 1'b0;
        ingameOn = 1'b0;
        n_cmp++; if (gameOver !== 1'b0 || win !== 1'b0) begin n_fail++; $display("FAIL rst_done_flags: got %b%b want 00", gameOver, win); end
        n_cmp++; if (matched !== 16'h0000 || revealed !== 16'h0000) begin n_fail++; $display("FAIL rst_done_masks: got %h/%h want 0000/0000", matched, revealed); end
        n_cmp++; if (score !== 4'd0 || attempts !== 8'd0) begin n_fail++; $display("FAIL rst_done_counts: got %0d/%0d want 0/0", score, attempts); end
        n_cmp++; if (time_left !== 7'd5) begin n_fail++; $display("FAIL rst_done_time: got %0d want 5", time_left); end
    endtask

    task automatic test_timeout();
        start_game();
        for (int i = 0; i < 10; i++) tick();
        n_cmp++; if (time_left !== 7'd4) begin n_fail++; $display("FAIL to_first_second: got %0d want 4", time_left); end
        for (int i = 0; i < 40; i++) tick();
        n_cmp++; if (time_left !== 7'd0) begin n_fail++; $display("FAIL to_zero: got %0d want 0", time_left); end
        n_cmp++; if (gameOver !== 1'b0) begin n_fail++; $display("FAIL to_not_yet_over: got %b want 0", gameOver); end
        tick();
        n_cmp++; if (gameOver !== 1'b1) begin n_fail++; $display("FAIL to_gameOver: got %b want 1", gameOver); end
        n_cmp++; if (win !== 1'b0) begin n_fail++; $display("FAIL to_win: got %b want 0", win); end
    endtask

    task automatic test_reset_in_hold();
        start_game();
        pick(4'd1);
        pick(4'd2);
        tick();
        userquit = 1'b1;
        tick();
        userquit = 1'b0;
        ingameOn = 1'b0;
        n_cmp++; if (revealed !== 16'h0000) begin n_fail++; $display("FAIL rst_hold_revealed: got %h want 0000", revealed); end
        n_cmp++; if (attempts !== 8'd0) begin n_fail++; $display("FAIL rst_hold_attempts: got %0d want 0", attempts); end
        n_cmp++; if (time_left !== 7'd5) begin n_fail++; $display("FAIL rst_hold_time: got %0d want 5", time_left); end
        tick();
        tick();
        n_cmp++; if (revealed !== 16'h0000) begin n_fail++; $display("FAIL rst_hold_stays_clear: got %h want 0000", revealed); end
    endtask

    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_ignored();
        test_win();
        test_reset_in_done();
        test_timeout();
        test_reset_in_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
